traffic_timer: RTL

TRAFFIC_TIMER -- requirements
Module: traffic_timer

---
 rtl/tlc_pkg.sv | 23 ++
 rtl/sec_prescaler.sv | 30 +++
 rtl/traffic_timer.sv | 97 +++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller: interval addresses,
// power-up interval defaults and the timer state encoding.
package tlc_pkg;

    localparam logic [1:0] BASE_ADD = 2'b00;
    localparam logic [1:0] EXT_ADD  = 2'b01;
    localparam logic [1:0] YEL_ADD  = 2'b10;

    localparam logic [3:0] DEF_BASE_SEC = 4'd6;
    localparam logic [3:0] DEF_EXT_SEC  = 4'd3;
    localparam logic [3:0] DEF_YEL_SEC  = 4'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } timer_state_t;

    // A zero-length interval would never expire cleanly, so it is stored as one second.
    function automatic logic [3:0] clamp_interval(input logic [3:0] value);
        return (value == 4'd0) ? 4'd1 : value;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-second strobe while enabled.
// The tick output is combinational and marks the edge on which the counter wraps.
module sec_prescaler #(
    parameter int CLK_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            PW   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] r_count;

    assign tick = enable && !clear && (r_count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || !enable || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_timer.sv
// Programmable seconds countdown for the traffic light controller: holds the
// base/ext/yellow intervals and pulses expired once per loaded interval.
module traffic_timer
    import tlc_pkg::*;
#(
    parameter int         CLK_PER_SEC = 100_000_000,
    parameter logic [3:0] DEF_BASE    = tlc_pkg::DEF_BASE_SEC,
    parameter logic [3:0] DEF_EXT     = tlc_pkg::DEF_EXT_SEC,
    parameter logic [3:0] DEF_YEL     = tlc_pkg::DEF_YEL_SEC
) (
    input  logic       clk,
    input  logic       sys_reset_n,
    input  logic       start_timer,
    input  logic [1:0] interval_address,
    input  logic       prog_sync,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic [3:0] seconds_left,
    output logic       tick_1hz
);

    logic [3:0]   r_base;
    logic [3:0]   r_ext;
    logic [3:0]   r_yel;
    timer_state_t r_state;
    logic [3:0]   r_secs;
    logic         r_expired;
    logic         r_tick;
    logic [3:0]   w_sel_value;
    logic         w_tick;

    sec_prescaler #(
        .CLK_PER_SEC(CLK_PER_SEC)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (sys_reset_n),
        .clear (start_timer),
        .enable(r_state == ST_COUNT),
        .tick  (w_tick)
    );

    always_comb begin
        w_sel_value = r_base;
        case (interval_address)
            EXT_ADD: w_sel_value = r_ext;
            YEL_ADD: w_sel_value = r_yel;
            default: w_sel_value = r_base;
        endcase
    end

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_base <= DEF_BASE;
            r_ext  <= DEF_EXT;
            r_yel  <= DEF_YEL;
        end else if (prog_sync) begin
            case (time_param_sel)
                BASE_ADD: r_base <= clamp_interval(time_value);
                EXT_ADD:  r_ext  <= clamp_interval(time_value);
                YEL_ADD:  r_yel  <= clamp_interval(time_value);
                default:  ;
            endcase
        end
    end

    // A start request always wins, including over an expiry on the same edge.
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state   <= ST_IDLE;
            r_secs    <= 4'd0;
            r_expired <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            r_tick    <= 1'b0;
            if (start_timer) begin
                r_secs  <= w_sel_value;
                r_state <= ST_COUNT;
            end else if ((r_state == ST_COUNT) && w_tick) begin
                r_tick <= 1'b1;
                if (r_secs <= 4'd1) begin
                    r_secs    <= 4'd0;
                    r_expired <= 1'b1;
                    r_state   <= ST_IDLE;
                end else begin
                    r_secs <= r_secs - 4'd1;
                end
            end
        end
    end

    assign expired      = r_expired;
    assign seconds_left = r_secs;
    assign tick_1hz     = r_tick;

endmodule
